// File: rtl/llr_hard_slicer_if.sv
// AXI-Stream bundle shared by the LLR input and the packed hard-decision output.
// tuser carries start-of-frame on the LLR side and is driven low on the output side.
interface llr_hard_slicer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/llr_hard_slicer.sv
// Slices LLRs to hard bits, packs them LSB-first into words and reports per-frame
// length, decision-flip count and framing errors.
module llr_hard_slicer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [DATA_WIDTH-1:0]    blklen,
  llr_hard_slicer_if.slave         s_axis_llr,
  input  logic                     s_axis_extr_tvalid,
  input  logic [DATA_WIDTH-1:0]    s_axis_extr_tdata,
  llr_hard_slicer_if.master        m_axis_hd,
  output logic                     frame_done,
  output logic [DATA_WIDTH-1:0]    frame_len,
  output logic [DATA_WIDTH-1:0]    flip_cnt,
  output logic                     err_len,
  output logic                     err_sof,
  output logic                     err_extr
);
  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] pack_reg, pack_next;
  logic [IW-1:0]         bit_idx_reg, bit_idx_next;
  logic [DATA_WIDTH-1:0] len_reg, len_next;
  logic [DATA_WIDTH-1:0] flip_reg, flip_next;
  logic [DATA_WIDTH-1:0] blklen_reg, blklen_next;
  logic                  err_sof_acc_reg, err_sof_acc_next;
  logic                  err_extr_acc_reg, err_extr_acc_next;
  logic                  ready_en_reg;

  logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
  logic                  out_valid_reg, out_valid_next;
  logic                  out_last_reg, out_last_next;

  logic                  done_reg, done_next;
  logic [DATA_WIDTH-1:0] st_len_reg, st_len_next;
  logic [DATA_WIDTH-1:0] st_flip_reg, st_flip_next;
  logic                  st_err_len_reg, st_err_len_next;
  logic                  st_err_sof_reg, st_err_sof_next;
  logic                  st_err_extr_reg, st_err_extr_next;

  logic                  llr_ready, acc, hb, flip_hit, publish, emit;
  logic [DATA_WIDTH-1:0] hb_word, merged;

  // Only the sign bits of the samples carry information for this block.
  wire unused_low_bits = &{1'b0, s_axis_llr.tdata[DATA_WIDTH-2:0],
                           s_axis_extr_tdata[DATA_WIDTH-2:0]};

  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + DATA_WIDTH'(1);
  endfunction

  // Ready depends only on registered state and downstream ready, never on tvalid.
  assign llr_ready         = ready_en_reg && !(out_valid_reg && !m_axis_hd.tready);
  assign s_axis_llr.tready = llr_ready;
  assign acc               = s_axis_llr.tvalid && llr_ready;
  assign hb                = s_axis_llr.tdata[DATA_WIDTH-1];
  assign flip_hit          = s_axis_extr_tvalid && (s_axis_extr_tdata[DATA_WIDTH-1] != hb);
  assign hb_word           = {{(DATA_WIDTH-1){1'b0}}, hb};
  assign merged            = pack_reg | (hb_word << bit_idx_reg);

  always_comb begin
    state_next        = state_reg;
    pack_next         = pack_reg;
    bit_idx_next      = bit_idx_reg;
    len_next          = len_reg;
    flip_next         = flip_reg;
    blklen_next       = blklen_reg;
    err_sof_acc_next  = err_sof_acc_reg;
    err_extr_acc_next = err_extr_acc_reg | (s_axis_extr_tvalid && !acc);
    publish           = 1'b0;
    emit              = 1'b0;
    out_data_next     = out_data_reg;
    out_last_next     = out_last_reg;
    out_valid_next    = out_valid_reg && !m_axis_hd.tready;

    case (state_reg)
      IDLE: begin
        if (acc) begin
          if (s_axis_llr.tuser) begin
            blklen_next = blklen;
            len_next    = DATA_WIDTH'(1);
            flip_next   = flip_hit ? DATA_WIDTH'(1) : '0;
            if (s_axis_llr.tlast) begin
              emit          = 1'b1;
              out_data_next = hb_word;
              out_last_next = 1'b1;
              publish       = 1'b1;
              pack_next     = '0;
              bit_idx_next  = '0;
            end else begin
              pack_next    = hb_word;
              bit_idx_next = IW'(1);
              state_next   = RUN;
            end
          end else begin
            // Stray beat outside a frame is dropped and charged to the next frame.
            err_sof_acc_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (acc) begin
          len_next = sat_inc(len_reg);
          if (flip_hit) flip_next = sat_inc(flip_reg);
          if (s_axis_llr.tuser) err_sof_acc_next = 1'b1;
          if (bit_idx_reg == LAST_IDX || s_axis_llr.tlast) begin
            emit          = 1'b1;
            out_data_next = merged;
            out_last_next = s_axis_llr.tlast;
            pack_next     = '0;
            bit_idx_next  = '0;
          end else begin
            pack_next    = merged;
            bit_idx_next = bit_idx_reg + IW'(1);
          end
          if (s_axis_llr.tlast) begin
            publish    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (emit) out_valid_next = 1'b1;

    done_next        = publish;
    st_len_next      = st_len_reg;
    st_flip_next     = st_flip_reg;
    st_err_len_next  = st_err_len_reg;
    st_err_sof_next  = st_err_sof_reg;
    st_err_extr_next = st_err_extr_reg;
    if (publish) begin
      st_len_next       = len_next;
      st_flip_next      = flip_next;
      st_err_len_next   = (len_next != blklen_next);
      st_err_sof_next   = err_sof_acc_next;
      st_err_extr_next  = err_extr_acc_next;
      err_sof_acc_next  = 1'b0;
      err_extr_acc_next = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg        <= IDLE;
      pack_reg         <= '0;
      bit_idx_reg      <= '0;
      len_reg          <= '0;
      flip_reg         <= '0;
      blklen_reg       <= '0;
      err_sof_acc_reg  <= 1'b0;
      err_extr_acc_reg <= 1'b0;
      ready_en_reg     <= 1'b0;
      out_data_reg     <= '0;
      out_valid_reg    <= 1'b0;
      out_last_reg     <= 1'b0;
      done_reg         <= 1'b0;
      st_len_reg       <= '0;
      st_flip_reg      <= '0;
      st_err_len_reg   <= 1'b0;
      st_err_sof_reg   <= 1'b0;
      st_err_extr_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pack_reg         <= pack_next;
      bit_idx_reg      <= bit_idx_next;
      len_reg          <= len_next;
      flip_reg         <= flip_next;
      blklen_reg       <= blklen_next;
      err_sof_acc_reg  <= err_sof_acc_next;
      err_extr_acc_reg <= err_extr_acc_next;
      ready_en_reg     <= 1'b1;
      out_data_reg     <= out_data_next;
      out_valid_reg    <= out_valid_next;
      out_last_reg     <= out_last_next;
      done_reg         <= done_next;
      st_len_reg       <= st_len_next;
      st_flip_reg      <= st_flip_next;
      st_err_len_reg   <= st_err_len_next;
      st_err_sof_reg   <= st_err_sof_next;
      st_err_extr_reg  <= st_err_extr_next;
    end
  end

  assign m_axis_hd.tdata  = out_data_reg;
  assign m_axis_hd.tvalid = out_valid_reg;
  assign m_axis_hd.tlast  = out_last_reg;
  assign m_axis_hd.tuser  = 1'b0;
  assign frame_done       = done_reg;
  assign frame_len        = st_len_reg;
  assign flip_cnt         = st_flip_reg;
  assign err_len          = st_err_len_reg;
  assign err_sof          = st_err_sof_reg;
  assign err_extr         = st_err_extr_reg;
endmodule
